mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator_if.sv | 25 ++
 rtl/mac_accumulator.sv | 96 +++++++++
 tb/tb_mac_accumulator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - product input stream and group-result output stream of the MAC accumulator
interface mac_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - signed product accumulator that emits one sum/count/overflow result per group
// Define MAC_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  mac_accumulator_if.slave bus
);
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_LIM = {CNT_W{1'b1}};

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx, acc_base, term, sum, acc_upd;
  logic [CNT_W-1:0]        count, count_nx, cnt_base, cnt_inc;
  logic                    ovf, ovf_nx, ovf_base, add_ovf;
  logic                    in_hs, out_hs, closes;

  // The held result lives in the accumulator registers themselves; out_valid gates its meaning.
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = count;
  assign bus.out_ovf   = ovf;
  assign bus.in_ready  = rst_n & ((state == ACCUM) | bus.out_ready);

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = (state == HOLD) & bus.out_ready;

  always_comb begin
    // A term accepted in HOLD always opens a fresh group, since in_ready there implies out_ready.
    acc_base = (state == HOLD) ? '0 : acc;
    cnt_base = (state == HOLD) ? '0 : count;
    ovf_base = (state == HOLD) ? 1'b0 : ovf;
    term     = {{(ACC_W-16){bus.in_product[15]}}, bus.in_product};
    sum      = acc_base + term;
    add_ovf  = (acc_base[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc_base[ACC_W-1]);
`ifdef MAC_ACC_SATURATE_EN
    acc_upd  = add_ovf ? (acc_base[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    acc_upd  = sum;
`endif
    cnt_inc  = cnt_base + CNT_W'(1);
    closes   = bus.in_last | (cnt_inc == CNT_LIM);
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    ovf_nx   = ovf;
    case (state)
      ACCUM: begin
        if (in_hs) begin
          acc_nx   = acc_upd;
          count_nx = cnt_inc;
          ovf_nx   = ovf_base | add_ovf;
          if (closes) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_hs) begin
          if (in_hs) begin
            acc_nx   = acc_upd;
            count_nx = cnt_inc;
            ovf_nx   = ovf_base | add_ovf;
            state_nx = closes ? HOLD : ACCUM;
          end else begin
            acc_nx   = '0;
            count_nx = '0;
            ovf_nx   = 1'b0;
            state_nx = ACCUM;
          end
        end
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized and directed bench for mac_accumulator against a group-level model
module tb_mac_accumulator;
  localparam int AW_A = 17;
  localparam int CW_A = 8;
  localparam int AW_B = 24;
  localparam int CW_B = 2;
`ifdef MAC_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_accumulator_if #(.ACC_W(AW_A), .CNT_W(CW_A)) if_a ();
  mac_accumulator_if #(.ACC_W(AW_B), .CNT_W(CW_B)) if_b ();

  mac_accumulator #(.ACC_W(AW_A), .CNT_W(CW_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  mac_accumulator #(.ACC_W(AW_B), .CNT_W(CW_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  logic        drv_v [2];
  logic        drv_l [2];
  logic        drv_or[2];
  logic [15:0] drv_p [2];

  assign if_a.in_valid   = drv_v[0];
  assign if_a.in_last    = drv_l[0];
  assign if_a.out_ready  = drv_or[0];
  assign if_a.in_product = drv_p[0];
  assign if_b.in_valid   = drv_v[1];
  assign if_b.in_last    = drv_l[1];
  assign if_b.out_ready  = drv_or[1];
  assign if_b.in_product = drv_p[1];

  logic   obs_rdy[2];
  logic   obs_ov [2];
  logic   obs_ovf[2];
  longint obs_sum[2];
  int     obs_cnt[2];

  assign obs_rdy[0] = if_a.in_ready;
  assign obs_ov[0]  = if_a.out_valid;
  assign obs_ovf[0] = if_a.out_ovf;
  assign obs_sum[0] = $signed(if_a.out_sum);
  assign obs_cnt[0] = int'(if_a.out_count);
  assign obs_rdy[1] = if_b.in_ready;
  assign obs_ov[1]  = if_b.out_valid;
  assign obs_ovf[1] = if_b.out_ovf;
  assign obs_sum[1] = $signed(if_b.out_sum);
  assign obs_cnt[1] = int'(if_b.out_count);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Group-level model: exact integer sums, clamped or wrapped into the signed ACC_W range.
  int     m_aw [2] = '{AW_A, AW_B};
  int     m_lim[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_ovf[2];
  bit     pend [2];
  longint p_sum[2];
  int     p_cnt[2];
  bit     p_ovf[2];

  task automatic model_clear(input int id);
    m_acc[id] = 0;
    m_cnt[id] = 0;
    m_ovf[id] = 1'b0;
  endtask

  task automatic sb_step(input int id);
    longint mx, mn, s;
    mx = (longint'(1) <<< (m_aw[id] - 1)) - 1;
    mn = -mx - 1;
    if (!rst_n) begin
      check("rst_in_ready", obs_rdy[id], 0);
      check("rst_out_valid", obs_ov[id], 0);
      check("rst_out_sum", obs_sum[id], 0);
      model_clear(id);
      pend[id] = 1'b0;
      return;
    end
    check("out_valid", obs_ov[id], pend[id]);
    if (obs_ov[id]) begin
      check("in_ready_hold", obs_rdy[id], drv_or[id]);
      if (pend[id]) begin
        check("out_sum", obs_sum[id], p_sum[id]);
        check("out_count", obs_cnt[id], p_cnt[id]);
        check("out_ovf", obs_ovf[id], p_ovf[id]);
      end
      if (drv_or[id]) pend[id] = 1'b0;
    end else begin
      check("in_ready_accum", obs_rdy[id], 1);
    end
    if (drv_v[id] && obs_rdy[id]) begin
      s = m_acc[id] + longint'($signed(drv_p[id]));
      if (s > mx) begin
        m_ovf[id] = 1'b1;
        s = SAT ? mx : s - 2 * (mx + 1);
      end else if (s < mn) begin
        m_ovf[id] = 1'b1;
        s = SAT ? mn : s + 2 * (mx + 1);
      end
      m_acc[id] = s;
      m_cnt[id]++;
      if (drv_l[id] || m_cnt[id] == m_lim[id]) begin
        pend[id]  = 1'b1;
        p_sum[id] = m_acc[id];
        p_cnt[id] = m_cnt[id];
        p_ovf[id] = m_ovf[id];
        model_clear(id);
      end
    end
  endtask

  always @(negedge clk) begin
    sb_step(0);
    sb_step(1);
  end

  task automatic send(input int id, input int prod, input bit last, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    drv_v[id] = 1'b1;
    drv_p[id] = 16'(prod);
    drv_l[id] = last;
    while (!got && waited < 50) begin
      @(negedge clk);
      got = obs_rdy[id];
      @(posedge clk);
      #1;
      waited++;
    end
    drv_v[id] = 1'b0;
    drv_l[id] = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic expect_result(input int id, input string tag, input longint sum, input int cnt, input bit ovf);
    @(negedge clk);
    check({tag, "_valid"}, obs_ov[id], 1);
    check({tag, "_sum"}, obs_sum[id], sum);
    check({tag, "_count"}, obs_cnt[id], cnt);
    check({tag, "_ovf"}, obs_ovf[id], ovf);
  endtask

  task automatic consume(input int id);
    drv_or[id] = 1'b1;
    @(posedge clk);
    #1;
    drv_or[id] = 1'b0;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_v[i] = 1'b0; drv_l[i] = 1'b0; drv_or[i] = 1'b0; drv_p[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 100, 0, w);
    send(0, -30, 0, w);
    send(0, 5, 1, w);
    expect_result(0, "basic", 75, 3, 0);
    consume(0);

    send(0, -16256, 1, w);
    drv_v[0] = 1'b1;
    drv_p[0] = 16'd1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_sum", obs_sum[0], -16256);
      check("hold_count", obs_cnt[0], 1);
      check("hold_in_ready", obs_rdy[0], 0);
      @(posedge clk); #1;
    end
    drv_v[0] = 1'b0;
    drv_or[0] = 1'b1;
    @(negedge clk);
    check("hold_ready_pass", obs_rdy[0], 1);
    @(posedge clk); #1;
    drv_or[0] = 1'b0;

    send(0, 3, 1, w);
    drv_or[0] = 1'b1;
    send(0, 7, 0, w);
    check("b2b_first_wait", w, 1);
    send(0, 1, 1, w);
    check("b2b_no_idle", w, 1);
    expect_result(0, "b2b", 8, 2, 0);
    @(posedge clk); #1;
    drv_or[0] = 1'b0;

    for (int i = 0; i < 5; i++) send(0, 16384, i == 4, w);
    expect_result(0, "ovf", SAT ? 65535 : -49152, 5, 1);
    consume(0);

    send(0, 50, 0, w);
    send(0, 60, 0, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 9, 1, w);
    expect_result(0, "post_rst", 9, 1, 0);
    consume(0);

    for (int i = 0; i < 3; i++) send(1, 1, 0, w);
    expect_result(1, "cnt_limit", 3, 3, 0);
    consume(1);

    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 2; i++) begin
        drv_v[i]  = ($urandom % 4) != 0;
        drv_p[i]  = 16'($urandom_range(0, 32640) - 16256);
        drv_l[i]  = ($urandom % 6) == 0;
        drv_or[i] = ($urandom % 3) != 0;
      end
      rst_n = ($urandom % 400) != 0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_v[i] = 1'b0; drv_or[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
